// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a program into a small instruction memory over a
// valid/ready word stream. It holds the CPU until the load completes, and
// serves instruction fetches from the same memory once the load is done.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset (memory contents are kept)
//   start        one-cycle load request; count is sampled with it
//   count[5:0]   number of words to load, valid range 1..DEPTH
//   wr_valid     qualifies wr_data
//   wr_data      program word (or trailing checksum word)
//   wr_ready     controller accepts a word this cycle
//   fetch_addr   CPU fetch byte address; the word index is fetch_addr[6:2]
//   fetch_instr  memory word at fetch_addr; reads as NOP (0) while busy
//   busy         load in progress
//   done         program loaded, CPU may run
//   cpu_hold     CPU must stay stalled or held in reset
//   err          sticky error flag for the last load attempt
//
// Configuration
//   IMEM_LOAD_CHECKSUM_EN  when defined, the program words are followed by
//                          one checksum word, which must equal the XOR of
//                          all program words. On a mismatch the load ends
//                          with err=1 in IDLE.
//
// state | meaning
// IDLE  | no valid program, CPU held
// LOAD  | accepting program words
// CHECK | accepting the checksum word (checksum build only)
// RUN   | program loaded, CPU released

module imem_load_ctrl #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  count,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic        err
);

  localparam logic [5:0] MAX_CNT = 6'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,S_CHECK = 2'd3
`endif
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  idx;
  logic [5:0]  remain;
  logic [31:0] mem [0:DEPTH-1];

  logic hs;
  logic start_ok;
  logic ld_init;
  logic err_set;
  logic wr_word;

  // Only the word-index bits of the fetch address select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:7], fetch_addr[1:0]};

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] xsum;
`endif

  assign hs       = wr_valid & wr_ready;
  assign start_ok = (count != 6'd0) && (count <= MAX_CNT);
  // The checksum word is consumed in CHECK and never lands in memory.
  assign wr_word  = hs && (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    ld_init  = 1'b0;
    err_set  = 1'b0;
    case (state)
      S_IDLE, S_RUN: begin
        if (state == S_RUN) begin
          done     = 1'b1;
          cpu_hold = 1'b0;
        end
        if (start) begin
          if (start_ok) begin
            ld_init  = 1'b1;
            state_nx = S_LOAD;
          end else begin
            err_set  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        // remain is a down-counter; terminal count 1 marks the last word.
        if (hs && remain == 6'd1) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_nx = S_CHECK;
`else
          state_nx = S_RUN;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        if (hs) begin
          if (wr_data == xsum) begin
            state_nx = S_RUN;
          end else begin
            err_set  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      remain <= '0;
      err    <= 1'b0;
    end else begin
      if (ld_init) begin
        idx    <= '0;
        remain <= count;
      end else if (wr_word) begin
        idx    <= idx + 5'd1;
        remain <= remain - 6'd1;
      end
      if (ld_init)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          xsum <= '0;
    else if (ld_init) xsum <= '0;
    else if (wr_word) xsum <= xsum ^ wr_data;
  end
`endif

  // Memory has no reset, so a reset never destroys a loaded program; a
  // word presented together with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_word) mem[idx] <= wr_data;
  end

  assign fetch_instr = busy ? 32'h0000_0000 : mem[fetch_addr[6:2]];

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, wr_valid, wr_ready, busy, done, cpu_hold, err;
  logic [5:0]  count;
  logic [31:0] wr_data, fetch_addr, fetch_instr;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .err(err)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] tb_x;

  localparam logic [31:0] W0 = 32'h2008_0005, W1 = 32'h2009_0007, W2 = 32'h0109_5020;
  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_0004, A2 = 32'h3333_0008, A3 = 32'h4444_000C;
  localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002;
  localparam logic [31:0] C0 = 32'hC000_0000, C1 = 32'hC000_0001;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0:       return fetch_instr;
      1:       return {31'b0, busy};
      2:       return {31'b0, done};
      3:       return {31'b0, cpu_hold};
      4:       return {31'b0, wr_ready};
      5:       return {31'b0, err};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains every pending expectation on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = probe(e.sel);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic want(string n, int sel, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic status(string n, logic b, logic d, logic h, logic r, logic e);
    want({n, ".busy"}, 1, {31'b0, b});
    want({n, ".done"}, 2, {31'b0, d});
    want({n, ".cpu_hold"}, 3, {31'b0, h});
    want({n, ".wr_ready"}, 4, {31'b0, r});
    want({n, ".err"}, 5, {31'b0, e});
    settle();
  endtask

  task automatic chk_fetch(string n, logic [31:0] a, logic [31:0] v);
    fetch_addr = a;
    want(n, 0, v);
    settle();
  endtask

  task automatic do_start(logic [5:0] c);
    start = 1'b1; count = c;
    step();
    start = 1'b0;
    tb_x  = 32'h0;
  endtask

  task automatic send(logic [31:0] w);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_data = w;
    while (!wr_ready && n < 20) begin
      step();
      n++;
    end
    if (!wr_ready) begin
      failures++;
      $display("FAIL handshake_timeout: got wr_ready=0 expected 1 for word %h", w);
    end else begin
      step();
      tb_x = tb_x ^ w;
    end
    wr_valid = 1'b0;
  endtask

  task automatic send_csum();
`ifdef IMEM_LOAD_CHECKSUM_EN
    send(tb_x);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = '0;
    wr_valid = 1'b0; wr_data = '0; fetch_addr = '0; tb_x = '0;
    step(); step();
    status("reset", 0, 0, 1, 0, 0);
    rst = 1'b0;
    step();

    // Basic three-word load.
    do_start(6'd3);
    status("load3_start", 1, 0, 1, 1, 0);
    chk_fetch("nop_while_busy", 32'd0, 32'h0);
    send(W0); send(W1);
    status("load3_mid", 1, 0, 1, 1, 0);
    send(W2); send_csum();
    status("load3_done", 0, 1, 0, 0, 0);
    chk_fetch("load3_w0", 32'd0, W0);
    chk_fetch("load3_w1", 32'd4, W1);
    chk_fetch("load3_w2", 32'd8, W2);

    // Reload from RUN with a 5-cycle gap in the stream.
    do_start(6'd4);
    status("load4_start", 1, 0, 1, 1, 0);
    send(A0); send(A1);
    repeat (5) step();
    status("load4_gap", 1, 0, 1, 1, 0);
    send(A2);
    status("load4_after3", 1, 0, 1, 1, 0);
    send(A3); send_csum();
    status("load4_done", 0, 1, 0, 0, 0);
    chk_fetch("load4_w0", 32'd0, A0);
    chk_fetch("load4_w1", 32'd4, A1);
    chk_fetch("load4_w2", 32'd8, A2);
    chk_fetch("load4_w3", 32'd12, A3);

    // Out-of-range counts and the upper bound.
    do_start(6'd0);
    status("cnt0", 0, 0, 1, 0, 1);
    chk_fetch("cnt0_mem", 32'd0, A0);
    do_start(6'd33);
    status("cnt33", 0, 0, 1, 0, 1);
    chk_fetch("cnt33_mem", 32'd4, A1);
    do_start(6'd32);
    status("cnt32_start", 1, 0, 1, 1, 0);
    rst = 1'b1; step(); rst = 1'b0;
    status("cnt32_rst", 0, 0, 1, 0, 0);

    // Reset mid-load, colliding with a handshake.
    do_start(6'd5);
    send(B0); send(B1);
    wr_valid = 1'b1; wr_data = B2; rst = 1'b1;
    step();
    rst = 1'b0; wr_valid = 1'b0;
    status("rst_mid", 0, 0, 1, 0, 0);
    chk_fetch("rst_mid_w0", 32'd0, B0);
    chk_fetch("rst_mid_w1", 32'd4, B1);
    chk_fetch("rst_mid_w2", 32'd8, A2);

    // Single-word reload from RUN.
    do_start(6'd2);
    send(C0); send(C1); send_csum();
    status("pre_reload", 0, 1, 0, 0, 0);
    do_start(6'd1);
    status("reload1_start", 1, 0, 1, 1, 0);
    chk_fetch("reload1_nop", 32'd4, 32'h0);
    send(32'hDEAD_BEEF); send_csum();
    status("reload1_done", 0, 1, 0, 0, 0);
    chk_fetch("reload1_w0", 32'd0, 32'hDEAD_BEEF);
    chk_fetch("reload1_w1", 32'd4, C1);

`ifdef IMEM_LOAD_CHECKSUM_EN
    do_start(6'd2);
    send(32'h0000_000F); send(32'h0000_00F0);
    status("csum_check_state", 1, 0, 1, 1, 0);
    send(32'h0000_00FF);
    status("csum_good", 0, 1, 0, 0, 0);
    do_start(6'd2);
    send(32'h0000_000F); send(32'h0000_00F0); send(32'h0000_0000);
    status("csum_bad", 0, 0, 1, 0, 1);
    chk_fetch("csum_bad_w0", 32'd0, 32'h0000_000F);
    chk_fetch("csum_bad_w1", 32'd4, 32'h0000_00F0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit instruction words held; the fetch index is fetch_addr[6:2].
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a program load.
REQ-005 SHALL have port count, input, 6, the number of words to load; it is sampled when start is accepted.
REQ-006 SHALL have port wr_valid, input, 1, which qualifies wr_data.
REQ-007 SHALL have port wr_data, input, 32, the program word (or checksum word, see REQ-027).
REQ-008 SHALL have port wr_ready, output, 1, meaning the controller accepts a word this cycle.
REQ-009 SHALL have port fetch_addr, input, 32, the CPU fetch byte address.
REQ-010 SHALL have port fetch_instr, output, 32, the instruction word returned for fetch_addr.
REQ-011 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-012 SHALL have port done, output, 1, meaning the program is loaded and the CPU may run.
REQ-013 SHALL have port cpu_hold, output, 1, meaning the CPU must stay stalled or in reset.
REQ-014 SHALL have port err, output, 1, a sticky error flag for the last load attempt.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD and RUN, plus CHECK when REQ-027 applies.
- Outputs in IDLE: cpu_hold=1, busy=0, done=0, wr_ready=0.
- Outputs in LOAD/CHECK: cpu_hold=1, busy=1, done=0, wr_ready=1.
- Outputs in RUN: cpu_hold=0, busy=0, done=1, wr_ready=0.
REQ-016 SHALL, on start in IDLE or RUN with count in 1..32: latch count, clear the write index to 0, clear err, and enter LOAD on the next cycle, so busy and wr_ready are 1 at t+1.
REQ-017 SHALL, on start with count=0 or count>32: set err=1, write nothing, and enter IDLE with memory unchanged.
REQ-018 SHALL ignore start while in LOAD or CHECK.
REQ-019 SHALL treat a handshake (wr_valid & wr_ready) as follows:
- write wr_data to memory[index];
- increment index;
- accept at most one word per cycle.
REQ-020 SHALL, on the handshake that writes word count-1, leave LOAD on the next edge; done=1 in the cycle after the last handshake.
REQ-021 SHALL hold state and index when wr_valid=0 in LOAD; there is no timeout.
REQ-022 SHALL leave entries at index >= count unchanged by a load.
REQ-023 SHALL produce fetch_instr combinationally as memory[fetch_addr[6:2]] when busy=0, and 32'h00000000 (NOP) when busy=1.
REQ-024 SHALL make a word written at edge t visible on fetch_instr from edge t onward, once busy=0.
REQ-025 SHALL, on a new start from RUN, assert cpu_hold again from the next cycle.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, produce the following regardless of state, including mid-load:
- state=IDLE, index=0, err=0, busy=0, done=0, cpu_hold=1, wr_ready=0;
- memory contents not cleared;
- rst takes priority over start and over a simultaneous handshake, and that handshake's word is not written.

Configuration
REQ-027 SHALL, with macro IMEM_LOAD_CHECKSUM_EN defined:
- keep a running XOR of the accepted program words;
- after word count-1, enter CHECK (wr_ready=1) and accept exactly one checksum word;
- on a match, enter RUN;
- on a mismatch, set err=1 and enter IDLE; memory keeps the written words.
REQ-028 SHALL, without IMEM_LOAD_CHECKSUM_EN, go LOAD->RUN directly per REQ-020, with no CHECK state and no XOR logic.

Verification
REQ-029 SHALL cover: rst, then start with count=3, words 0x20080005, 0x20090007, 0x01095020 -> done=1 one cycle after the third handshake; fetch_addr 0,4,8 return those words; cpu_hold=0.
REQ-030 SHALL cover: count=4 with wr_valid deasserted for 5 cycles between words 1 and 2 -> busy stays 1, index holds, done only after the 4th handshake.
REQ-031 SHALL cover: count=0 and count=33 -> err=1, no memory change, state IDLE, cpu_hold=1.
REQ-032 SHALL cover: rst asserted after 2 of 5 words -> next cycle IDLE, cpu_hold=1, busy=0; words 0-1 written, word 2 (presented with rst) not written.
REQ-033 SHALL cover: reload from RUN with count=1, data 0xDEADBEEF -> cpu_hold=1 during the load, fetch_instr=0 while busy; afterwards addr 0 returns 0xDEADBEEF and addr 4 keeps its previous value.
REQ-034 SHALL cover, with IMEM_LOAD_CHECKSUM_EN: words 0x0000000F, 0x000000F0 followed by checksum 0x000000FF -> RUN. The same words followed by checksum 0x00000000 -> err=1, IDLE.
